// File: rtl/rv32v_multiplier.sv
// Sequential radix-4 shift-add multiplier for the rv32v vector lane.
// Independent operand signedness covers vmul/vmulh/vmulhu/vmulhsu with a fixed NUM_BITS/2 cycle latency.
module rv32v_multiplier #(
    parameter int unsigned NUM_BITS = 32
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    start,
    input  logic                    is_signed_a,
    input  logic                    is_signed_b,
    input  logic [NUM_BITS-1:0]     multiplicand,
    input  logic [NUM_BITS-1:0]     multiplier,
    output logic [2*NUM_BITS-1:0]   product,
    output logic                    finished
);

    localparam int unsigned W  = NUM_BITS;
    localparam int unsigned PW = 2 * NUM_BITS;
    localparam int unsigned AW = NUM_BITS + 2;
    localparam int unsigned CW = $clog2(NUM_BITS / 2 + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [W-1:0]    mag_a_q, mag_a_d;
    logic            negate_q, negate_d;
    logic            finished_q, finished_d;

    logic            neg_a, neg_b;
    logic [W-1:0]    mag_b;
    logic [AW-1:0]   a1, a2, a3, pp, sum;
    logic [PW+1:0]   wide;
    logic [PW-1:0]   shifted;

    // Radix-4 partial product select and carry-preserving accumulate.
    always_comb begin
        a1 = AW'(mag_a_q);
        a2 = a1 << 1;
        a3 = a2 + a1;
        case (acc_q[1:0])
            2'd0:    pp = '0;
            2'd1:    pp = a1;
            2'd2:    pp = a2;
            default: pp = a3;
        endcase
        sum     = AW'(acc_q[PW-1:W]) + pp;
        wide    = {sum, acc_q[W-1:0]};
        shifted = PW'(wide >> 2);
    end

    always_comb begin
        neg_a = is_signed_a & multiplicand[W-1];
        neg_b = is_signed_b & multiplier[W-1];
        mag_b = neg_b ? (W'(0) - multiplier) : multiplier;
    end

    // Next-state and datapath update; start overrides every state.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        mag_a_d    = mag_a_q;
        negate_d   = negate_q;
        finished_d = 1'b0;
        if (start) begin
            state_d  = BUSY;
            count_d  = CW'(NUM_BITS / 2);
            acc_d    = {W'(0), mag_b};
            mag_a_d  = neg_a ? (W'(0) - multiplicand) : multiplicand;
            negate_d = neg_a ^ neg_b;
        end else begin
            case (state_q)
                BUSY: begin
                    count_d = count_q - CW'(1);
                    acc_d   = shifted;
                    if (count_q == CW'(1)) begin
                        state_d = DONE;
                        if (negate_q) begin
                            acc_d = PW'(0) - shifted;
                        end
                    end
                end
                default: ;
            endcase
        end
        finished_d = (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            mag_a_q    <= '0;
            negate_q   <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            mag_a_q    <= mag_a_d;
            negate_q   <= negate_d;
            finished_q <= finished_d;
        end
    end

    assign product  = acc_q;
    assign finished = finished_q;

endmodule

// File: tb/tb_rv32v_multiplier.sv
// Directed self-checking bench for rv32v_multiplier (NUM_BITS=32).
// Each task drives one scenario and compares against hand-computed products.
module tb_rv32v_multiplier;

    logic        CLK;
    logic        nRST;
    logic        start;
    logic        is_signed_a;
    logic        is_signed_b;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] product;
    logic        finished;

    int check_cnt = 0;
    int pass_cnt  = 0;

    rv32v_multiplier #(.NUM_BITS(32)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .start        (start),
        .is_signed_a  (is_signed_a),
        .is_signed_b  (is_signed_b),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .finished     (finished)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive a start pulse; returns 1ns after the start edge with start low.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic sa, input logic sb);
        multiplicand = a;
        multiplier   = b;
        is_signed_a  = sa;
        is_signed_b  = sb;
        start        = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    // Count edges after the start edge until finished is seen (bounded).
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(posedge CLK);
            #1;
            cycles++;
        end while (!finished && cycles < 40);
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        start = 1'b0;
        is_signed_a = 1'b0;
        is_signed_b = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        #3;
        check_cnt++;
        if (finished !== 1'b0) $display("FAIL reset_finished: got %b expected 0", finished);
        else pass_cnt++;
        check_cnt++;
        if (product !== 64'd0) $display("FAIL reset_product: got %h expected 0", product);
        else pass_cnt++;
        @(negedge CLK);
        nRST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_cnt++;
        if (finished !== 1'b0) $display("FAIL idle_finished: got %b expected 0", finished);
        else pass_cnt++;
    endtask

    task automatic test_unsigned;
        int cyc;
        start_op(32'd7, 32'd6, 1'b0, 1'b0);
        wait_done(cyc);
        check_cnt++;
        if (cyc !== 16) $display("FAIL unsigned_latency: got %0d expected 16", cyc);
        else pass_cnt++;
        check_cnt++;
        if (product !== 64'h0000_0000_0000_002A) $display("FAIL unsigned_7x6: got %h expected 000000000000002a", product);
        else pass_cnt++;
        repeat (4) @(posedge CLK);
        #1;
        check_cnt++;
        if (finished !== 1'b1 || product !== 64'h2A)
            $display("FAIL done_hold: got finished=%b product=%h expected 1 000000000000002a", finished, product);
        else pass_cnt++;
    endtask

    task automatic test_signed;
        int cyc;
        start_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
        check_cnt++;
        if (finished !== 1'b0) $display("FAIL start_drops_finished: got %b expected 0", finished);
        else pass_cnt++;
        wait_done(cyc);
        check_cnt++;
        if (cyc !== 16) $display("FAIL signed_latency: got %0d expected 16", cyc);
        else pass_cnt++;
        check_cnt++;
        if (product !== 64'hFFFF_FFFF_FFFF_FFF1) $display("FAIL signed_m3x5: got %h expected fffffffffffffff1", product);
        else pass_cnt++;
    endtask

    task automatic test_boundaries;
        int cyc;
        start_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        wait_done(cyc);
        check_cnt++;
        if (cyc !== 16 || product !== 64'h4000_0000_0000_0000)
            $display("FAIL min_x_min: got cyc=%0d product=%h expected 16 4000000000000000", cyc, product);
        else pass_cnt++;
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_done(cyc);
        check_cnt++;
        if (cyc !== 16 || product !== 64'hFFFF_FFFE_0000_0001)
            $display("FAIL umax_x_umax: got cyc=%0d product=%h expected 16 fffffffe00000001", cyc, product);
        else pass_cnt++;
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_done(cyc);
        check_cnt++;
        if (cyc !== 16 || product !== 64'hFFFF_FFFF_0000_0001)
            $display("FAIL mulhsu: got cyc=%0d product=%h expected 16 ffffffff00000001", cyc, product);
        else pass_cnt++;
        start_op(32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_done(cyc);
        check_cnt++;
        if (cyc !== 16 || product !== 64'd0)
            $display("FAIL zero_x_m1: got cyc=%0d product=%h expected 16 0000000000000000", cyc, product);
        else pass_cnt++;
    endtask

    task automatic test_restart;
        int cyc;
        logic seen;
        seen = 1'b0;
        start_op(32'd100, 32'd3, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(posedge CLK);
            #1;
            seen |= finished;
        end
        start_op(32'd9, 32'd9, 1'b0, 1'b0);
        seen |= finished;
        cyc = 0;
        do begin
            @(posedge CLK);
            #1;
            cyc++;
            if (cyc < 16) seen |= finished;
        end while (!finished && cyc < 40);
        check_cnt++;
        if (seen !== 1'b0) $display("FAIL restart_no_pulse: got %b expected 0", seen);
        else pass_cnt++;
        check_cnt++;
        if (cyc !== 16) $display("FAIL restart_latency: got %0d expected 16", cyc);
        else pass_cnt++;
        check_cnt++;
        if (product !== 64'd81) $display("FAIL restart_9x9: got %h expected 0000000000000051", product);
        else pass_cnt++;
    endtask

    task automatic test_start_on_final;
        int cyc;
        start_op(32'd5, 32'd5, 1'b0, 1'b0);
        repeat (15) @(posedge CLK);
        #1;
        start_op(32'd11, 32'd13, 1'b0, 1'b0);
        check_cnt++;
        if (finished !== 1'b0) $display("FAIL start_wins_final: got %b expected 0", finished);
        else pass_cnt++;
        wait_done(cyc);
        check_cnt++;
        if (cyc !== 16 || product !== 64'd143)
            $display("FAIL final_restart_11x13: got cyc=%0d product=%h expected 16 000000000000008f", cyc, product);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int cyc;
        start_op(32'd123, 32'd45, 1'b0, 1'b0);
        repeat (5) @(posedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        check_cnt++;
        if (finished !== 1'b0 || product !== 64'd0)
            $display("FAIL reset_mid: got finished=%b product=%h expected 0 0000000000000000", finished, product);
        else pass_cnt++;
        #2;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        start_op(32'd2, 32'd2, 1'b0, 1'b0);
        wait_done(cyc);
        check_cnt++;
        if (cyc !== 16 || product !== 64'd4)
            $display("FAIL after_reset_2x2: got cyc=%0d product=%h expected 16 0000000000000004", cyc, product);
        else pass_cnt++;
    endtask

    task automatic test_operand_toggle;
        int cyc;
        start_op(32'd12345, 32'd6789, 1'b0, 1'b0);
        cyc = 0;
        do begin
            multiplicand = $urandom;
            multiplier   = $urandom;
            is_signed_a  = 1'($urandom);
            is_signed_b  = 1'($urandom);
            @(posedge CLK);
            #1;
            cyc++;
        end while (!finished && cyc < 40);
        check_cnt++;
        if (cyc !== 16 || product !== 64'd83810205)
            $display("FAIL toggle_operands: got cyc=%0d product=%h expected 16 0000000004fed79d", cyc, product);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_boundaries();
        test_restart();
        test_start_on_final();
        test_reset_mid();
        test_operand_toggle();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/rv32v_multiplier.md
Name: rv32v_multiplier

Overview:
Sequential radix-4 shift-add integer multiplier for the rv32v vector execution lane; it is the multiply counterpart of the lane's iterative divider. It accepts two NUM_BITS operands with independent signedness, so one unit serves vmul, vmulh, vmulhu and vmulhsu. It produces the full 2*NUM_BITS product over a fixed NUM_BITS/2 iteration cycles, using the same start/finished handshake as the lane divider.

Parameters:
NUM_BITS, 32, operand width; must be even and >= 4.

Ports:
CLK  input  1  clock, all state updates on rising edge
nRST  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse: sample operands and begin (or restart) an operation
is_signed_a  input  1  multiplicand is two's-complement signed
is_signed_b  input  1  multiplier is two's-complement signed
multiplicand  input  NUM_BITS  operand A, valid only in the start cycle
multiplier  input  NUM_BITS  operand B, valid only in the start cycle
product  output  2*NUM_BITS  full product; low half = vmul result, high half = vmulh* result
finished  output  1  high while product holds a completed result

Behaviour:
- Reset (async, nRST=0): state=IDLE, count=0, all product/accumulator registers=0, negate flag=0, finished=0.
- FSM states:
  - IDLE: entered only from reset.
  - BUSY: iterating.
  - DONE: result held.
- Transitions:
  - start=1 in any state -> BUSY. A start during BUSY aborts the current operation and restarts with the new operands. A start during DONE drops finished on that edge.
  - BUSY -> DONE on the edge that completes iteration 1 (count==1).
  - DONE holds until the next start. IDLE holds until start.
- finished = (state==DONE), registered.
- Latency: start sampled at edge 0; iterations on edges 1..NUM_BITS/2; finished=1 and product valid after edge NUM_BITS/2 (edge 16 for NUM_BITS=32). Latency is fixed and does not depend on the data.
- Operand capture on the start edge:
  - mag_a = (is_signed_a & multiplicand[MSB]) ? two's-complement negation : multiplicand. Same rule for mag_b from multiplier and is_signed_b.
  - negate = (is_signed_a & multiplicand[MSB]) XOR (is_signed_b & multiplier[MSB]).
  - count = NUM_BITS/2. Accumulator high half = 0. Low half = mag_b.
  - Magnitudes are treated as unsigned NUM_BITS values, so the most-negative input gives 2^(NUM_BITS-1) with no overflow.
- Precompute A1=mag_a, A2=mag_a<<1, A3=A2+A1, each NUM_BITS+2 bits wide.
- Each BUSY cycle:
  - digit = acc_lo[1:0]; pp = {0, A1, A2, A3}[digit].
  - sum = acc_hi + pp, computed in NUM_BITS+2 bits; the carry must not be lost.
  - {acc_hi, acc_lo} <= {sum, acc_lo} >> 2, a 2*NUM_BITS+2 bit shift whose result is truncated to 2*NUM_BITS.
  - count decrements by 1.
- Final iteration (count==1): if negate, the value written to the product register is the 2*NUM_BITS two's-complement negation of the shifted result. Otherwise it is the shifted result unmodified. A zero magnitude with negate=1 yields 0.
- product is driven directly from the accumulator register. It is intermediate garbage while BUSY, exact in DONE, and stable until the next start edge.
- Operand inputs are ignored outside the start cycle. Changing them while BUSY must not affect the result.
- Reset asserted mid-operation: immediate return to the reset values above; no result is produced.
- Simultaneous start and final iteration: start wins; finished stays 0 and the new operation begins.

Test Plan:
- Unsigned 7*6 (is_signed_a=0, is_signed_b=0) -> finished rises exactly 16 cycles after the start edge; product=0x0000_0000_0000_002A.
- Signed -3*5 (0xFFFFFFFD, 0x00000005, both signed) -> product=0xFFFF_FFFF_FFFF_FFF1.
- Signed 0x80000000*0x80000000 -> product=0x4000_0000_0000_0000. Unsigned 0xFFFFFFFF*0xFFFFFFFF -> product=0xFFFF_FFFE_0000_0001.
- vmulhsu case, a=0xFFFFFFFF signed, b=0xFFFFFFFF unsigned -> product=0xFFFF_FFFF_0000_0001. Signed 0 * -1 -> product=0.
- Restart mid-operation: start 100*3, then at cycle 8 start 9*9 -> finished stays 0 until 16 cycles after the second start; product=81; no intermediate finished pulse.
- Reset mid-operation at cycle 5 -> finished=0 and product=0 immediately; a subsequent start 2*2 -> product=4 after 16 cycles. Operands toggled randomly while BUSY -> result unaffected.
